// File: rtl/bit_population_counter.sv
// Pipelined popcount: zero-pad to whole nibbles, count each nibble with a
// small table, then reduce through a binary adder tree with spread-out stages.
module bit_population_counter #(
  parameter int WIDTH     = 128,
  parameter int PIPE_SIZE = 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   data_val_i,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o
);

  localparam int OW     = $clog2(WIDTH) + 1;
  localparam int NIB    = (WIDTH + 3) / 4;
  localparam int PADW   = 4 * NIB;
  localparam int LEVELS = $clog2(NIB);
  localparam int INNER  = (PIPE_SIZE - 1 < LEVELS) ? PIPE_SIZE - 1 : LEVELS;
  localparam int OUTS   = PIPE_SIZE - INNER;

  function automatic int nodes_at(int p);
    return (NIB + (1 << p) - 1) >> p;
  endfunction

  // Boundary p gets a register when the even spread of INNER stages over
  // LEVELS boundaries steps between p and p+1.
  function automatic bit reg_at(int p);
    if (LEVELS == 0) return 1'b0;
    return ((p + 1) * INNER) / LEVELS > (p * INNER) / LEVELS;
  endfunction

  function automatic logic [2:0] nib_count(logic [3:0] n);
    case (n)
      4'h0:                         return 3'd0;
      4'h1, 4'h2, 4'h4, 4'h8:       return 3'd1;
      4'h3, 4'h5, 4'h6, 4'h9,
      4'ha, 4'hc:                   return 3'd2;
      4'h7, 4'hb, 4'hd, 4'he:       return 3'd3;
      default:                      return 3'd4;
    endcase
  endfunction

  logic [PADW-1:0] data_pad;
  assign data_pad = PADW'(data_i);

  // Every partial sum is bounded by WIDTH, so OW bits hold any node exactly.
  for (genvar p = 0; p <= LEVELS; p++) begin : g_lvl
    localparam int N   = nodes_at(p);
    localparam bit REG = (p < LEVELS) && reg_at(p);

    logic [OW-1:0] sum_c [N];
    logic [OW-1:0] sum_o [N];
    logic          val_c;
    logic          val_o;

    if (p == 0) begin : g_leaf
      assign val_c = data_val_i;
      for (genvar i = 0; i < N; i++) begin : g_nib
        assign sum_c[i] = OW'(nib_count(data_pad[4*i +: 4]));
      end
    end else begin : g_add
      localparam int NP = nodes_at(p - 1);
      assign val_c = g_lvl[p-1].val_o;
      for (genvar i = 0; i < N; i++) begin : g_node
        if (2*i + 1 < NP) begin : g_pair
          assign sum_c[i] = g_lvl[p-1].sum_o[2*i] + g_lvl[p-1].sum_o[2*i+1];
        end else begin : g_single
          assign sum_c[i] = g_lvl[p-1].sum_o[2*i];
        end
      end
    end

    if (REG) begin : g_reg
      always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
          val_o <= 1'b0;
          sum_o <= '{default: '0};
        end else begin
          val_o <= val_c;
          sum_o <= sum_c;
        end
      end
    end else begin : g_wire
      assign val_o = val_c;
      assign sum_o = sum_c;
    end
  end

  // Output register plus any surplus stages as plain delays; each holds
  // its last result while no valid word passes through.
  logic [OW-1:0]   out_q [OUTS];
  logic [OUTS-1:0] out_v;

  always_ff @(posedge clk_i or negedge srst_i) begin
    if (!srst_i) begin
      out_v <= '0;
      out_q <= '{default: '0};
    end else begin
      out_v[0] <= g_lvl[LEVELS].val_o;
      if (g_lvl[LEVELS].val_o) out_q[0] <= g_lvl[LEVELS].sum_o[0];
      for (int k = 1; k < OUTS; k++) begin
        out_v[k] <= out_v[k-1];
        if (out_v[k-1]) out_q[k] <= out_q[k-1];
      end
    end
  end

  assign data_o     = out_q[OUTS-1];
  assign data_val_o = out_v[OUTS-1];

endmodule

// File: tb/tb_bit_population_counter.sv
// Several popcount configurations share one stimulus stream; a log of issued
// words feeds per-configuration monitors that compare against a bit-count model.
module tb_bit_population_counter;

  localparam int NCFG = 5;
  localparam int CFG_W [NCFG] = '{128, 7, 32, 1, 7};
  localparam int CFG_P [NCFG] = '{3, 1, 2, 4, 4};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] din = '0;
  logic         vin = 1'b0;
  int           cyc = 0;
  int           n_pass = 0;
  int           n_total = 0;
  event         done_ev;

  logic [127:0] exp_word [$];
  int           exp_cyc  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int model_pop(logic [127:0] w, int width);
    int n = 0;
    for (int i = 0; i < width; i++) if (w[i]) n++;
    return n;
  endfunction

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(logic [127:0] w, bit v);
    @(negedge clk);
    din = w;
    vin = v;
    if (v) begin
      exp_word.push_back(w);
      exp_cyc.push_back(cyc + 1);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int W  = CFG_W[c];
    localparam int P  = CFG_P[c];
    localparam int OW = $clog2(W) + 1;

    logic [OW-1:0] dout;
    logic          vout;
    int            rd_idx = 0;
    int            last = 0;

    bit_population_counter #(.WIDTH(W), .PIPE_SIZE(P)) dut (
      .clk_i(clk), .srst_i(rst_n), .data_i(din[W-1:0]),
      .data_val_i(vin), .data_o(dout), .data_val_o(vout)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        chk($sformatf("rst_val_w%0d_p%0d", W, P), int'(vout), 0);
        chk($sformatf("rst_data_w%0d_p%0d", W, P), int'(dout), 0);
        last   = 0;
        rd_idx = exp_word.size();
      end else if (vout) begin
        if (rd_idx >= exp_word.size()) begin
          chk($sformatf("spurious_w%0d_p%0d", W, P), int'(vout), 0);
        end else begin
          last = model_pop(exp_word[rd_idx], W);
          chk($sformatf("count_w%0d_p%0d", W, P), int'(dout), last);
          chk($sformatf("latency_w%0d_p%0d", W, P), cyc - exp_cyc[rd_idx], P - 1);
          rd_idx++;
        end
      end else begin
        chk($sformatf("hold_w%0d_p%0d", W, P), int'(dout), last);
      end
    end

    always @(negedge rst_n) begin
      #1;
      chk($sformatf("async_rst_val_w%0d_p%0d", W, P), int'(vout), 0);
      chk($sformatf("async_rst_data_w%0d_p%0d", W, P), int'(dout), 0);
    end

    always @(done_ev) chk($sformatf("pulse_count_w%0d_p%0d", W, P), rd_idx, exp_word.size());
  end

  initial begin
    logic [127:0] w;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single zero word after reset
    drive('0, 1'b1);
    repeat (6) drive(rand_word(), 1'b0);

    // thermometer sweep including all-ones
    for (int i = 0; i <= 128; i++) begin
      w = (i == 128) ? '1 : ((128'd1 << i) - 128'd1);
      drive(w, 1'b1);
    end
    drive(128'h55, 1'b1);
    repeat (6) drive(rand_word(), 1'b0);

    // valid pattern 1,0,1,1 exposes gaps and hold
    drive(rand_word(), 1'b1);
    drive(rand_word(), 1'b0);
    drive(rand_word(), 1'b1);
    drive(rand_word(), 1'b1);
    repeat (6) drive(rand_word(), 1'b0);

    // random words: back-to-back then spaced
    for (int k = 0; k < 50; k++) drive(rand_word(), 1'b1);
    for (int k = 0; k < 50; k++) begin
      repeat ($urandom_range(0, 2)) drive(rand_word(), 1'b0);
      drive(rand_word(), 1'b1);
    end
    repeat (6) drive(rand_word(), 1'b0);

    // reset with two words in flight, then idle to expose stale results
    drive(rand_word(), 1'b1);
    drive(rand_word(), 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    vin   = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) drive(rand_word(), 1'b0);

    // traffic resumes after reset
    for (int k = 0; k < 10; k++) drive(rand_word(), 1'b1);
    repeat (10) drive(rand_word(), 1'b0);

    -> done_ev;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
